// File: rtl/evt_counter_pkg.sv
// Shared constants and types for the multi-channel event counter.
// Holds the default baud terminal and the channel-chaining mode.
package evt_counter_pkg;

    localparam int DEFAULT_BAUD_MAX = 115199;

    typedef enum logic {
        MODE_INDEP   = 1'b0,
        MODE_CASCADE = 1'b1
    } mode_e;

    function automatic mode_e mode_of(input int cascade);
        return (cascade != 0) ? MODE_CASCADE : MODE_INDEP;
    endfunction

endpackage

// File: rtl/evt_counter_chan.sv
// One modulo-counter channel with a shadowed terminal value and a registered wrap strobe.
// Latency 1 cycle from event to count. No backpressure: every qualified event is counted.
module evt_counter_chan
    import evt_counter_pkg::*;
#(
    parameter int WIDTH     = 27,
    parameter int RESET_MAX = DEFAULT_BAUD_MAX
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             src_evt,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] max_val,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             wrap_cond
);

    typedef logic [WIDTH-1:0] cnt_t;

    cnt_t active_max;
    cnt_t pending_max;
    logic pending_valid;
    logic cnt_evt;
    logic at_term;
    logic apply;

    assign cnt_evt   = src_evt & en;
    // ">=" so a count left above a freshly lowered terminal wraps instead of running on
    assign at_term   = (count >= active_max);
    assign wrap_cond = cnt_evt & at_term & ~clr;
    assign apply     = wrap_cond | clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            wrap  <= 1'b0;
        end else if (clr) begin
            count <= '0;
            wrap  <= 1'b0;
        end else if (cnt_evt) begin
            if (at_term) begin
                count <= '0;
                wrap  <= 1'b1;
            end else begin
                count <= count + cnt_t'(1);
                wrap  <= 1'b0;
            end
        end else begin
            wrap <= 1'b0;
        end
    end

    // A load coinciding with a wrap or clear bypasses the shadow register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_max    <= WIDTH'(RESET_MAX);
            pending_max   <= WIDTH'(RESET_MAX);
            pending_valid <= 1'b0;
        end else if (apply && load) begin
            active_max    <= max_val;
            pending_valid <= 1'b0;
        end else if (apply && pending_valid) begin
            active_max    <= pending_max;
            pending_valid <= 1'b0;
        end else if (load) begin
            pending_max   <= max_val;
            pending_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/evt_counter_mc.sv
// N-channel modulo event counter, optionally cascaded into one wide counter.
// Latency 1 cycle event to count/wrap/carry. No backpressure; carry chain is combinational.
module evt_counter_mc
    import evt_counter_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int WIDTH     = 27,
    parameter int RESET_MAX = DEFAULT_BAUD_MAX,
    parameter int CASCADE   = 0
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic [N_CH-1:0]       evt_in,
    input  logic [N_CH-1:0]       en_in,
    input  logic [N_CH-1:0]       clr_in,
    input  logic [N_CH-1:0]       load_in,
    input  logic [WIDTH-1:0]      max_val_in,
    output logic [N_CH*WIDTH-1:0] count_out,
    output logic [N_CH-1:0]       wrap_out,
    output logic                  carry_out
);

    localparam mode_e MODE = mode_of(CASCADE);

    if (N_CH < 1) begin : g_bad_n_ch
        $error("evt_counter_mc: N_CH must be at least 1");
    end
    if (RESET_MAX < 0 || longint'(RESET_MAX) >= (longint'(1) << WIDTH)) begin : g_bad_reset_max
        $error("evt_counter_mc: RESET_MAX does not fit in WIDTH bits");
    end

    logic [N_CH-1:0] wrap_cond;
    logic            last_wrap_cond;
    logic            unused_bits;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic src_evt;
        logic wc;

        // In cascade mode upper stages are clocked by the lower stage's wrap, not by evt_in
        if (i == 0 || MODE == MODE_INDEP) begin : g_src_ext
            assign src_evt = evt_in[i];
        end else begin : g_src_chain
            assign src_evt = g_ch[i-1].wc;
        end

        evt_counter_chan #(
            .WIDTH     (WIDTH),
            .RESET_MAX (RESET_MAX)
        ) u_chan (
            .clk       (clk_in),
            .rst_n     (rst_n_in),
            .src_evt   (src_evt),
            .en        (en_in[i]),
            .clr       (clr_in[i]),
            .load      (load_in[i]),
            .max_val   (max_val_in),
            .count     (count_out[i*WIDTH +: WIDTH]),
            .wrap      (wrap_out[i]),
            .wrap_cond (wc)
        );

        assign wrap_cond[i] = wc;
        if (i == N_CH - 1) begin : g_last
            assign last_wrap_cond = wc;
        end
    end

    assign unused_bits = ^{evt_in, wrap_cond};

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            carry_out <= 1'b0;
        end else begin
            carry_out <= last_wrap_cond;
        end
    end

endmodule

// File: tb/tb_evt_counter_mc.sv
// Bench for evt_counter_mc: directed scenarios plus randomized traffic against a reference model,
// one independent 4-channel instance and one 3-channel cascaded instance.
module tb_evt_counter_mc;
    import evt_counter_pkg::*;

    localparam int W  = 27;
    localparam int N  = 4;
    localparam int NC = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic [N-1:0]     evt, en, clr, load;
    logic [W-1:0]     max_val;
    logic [N*W-1:0]   count;
    logic [N-1:0]     wrap;
    logic             carry;

    logic [NC-1:0]    c_evt, c_en, c_clr, c_load;
    logic [W-1:0]     c_max;
    logic [NC*W-1:0]  c_count;
    logic [NC-1:0]    c_wrap;
    logic             c_carry;

    evt_counter_mc #(.N_CH(N), .WIDTH(W), .RESET_MAX(DEFAULT_BAUD_MAX), .CASCADE(0)) dut (
        .clk_in(clk), .rst_n_in(rst_n), .evt_in(evt), .en_in(en), .clr_in(clr),
        .load_in(load), .max_val_in(max_val), .count_out(count), .wrap_out(wrap),
        .carry_out(carry)
    );

    evt_counter_mc #(.N_CH(NC), .WIDTH(W), .RESET_MAX(DEFAULT_BAUD_MAX), .CASCADE(1)) dut_c (
        .clk_in(clk), .rst_n_in(rst_n), .evt_in(c_evt), .en_in(c_en), .clr_in(c_clr),
        .load_in(c_load), .max_val_in(c_max), .count_out(c_count), .wrap_out(c_wrap),
        .carry_out(c_carry)
    );

    int vectors    = 0;
    int miscompares = 0;

    // Reference model of the independent instance: plain integers per channel
    longint m_cnt [N];
    longint m_amax[N];
    longint m_pmax[N];
    bit     m_pv  [N];
    bit     m_wrap[N];
    bit     m_carry;

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_cnt[i] = 0; m_amax[i] = DEFAULT_BAUD_MAX; m_pmax[i] = 0;
            m_pv[i] = 1'b0; m_wrap[i] = 1'b0;
        end
        m_carry = 1'b0;
    endfunction

    function automatic void model_step();
        for (int i = 0; i < N; i++) begin
            bit apply = 1'b0;
            if (clr[i]) begin
                m_cnt[i] = 0; m_wrap[i] = 1'b0; apply = 1'b1;
            end else if (evt[i] && en[i]) begin
                if (m_cnt[i] + 1 > m_amax[i]) begin
                    m_cnt[i] = 0; m_wrap[i] = 1'b1; apply = 1'b1;
                end else begin
                    m_cnt[i] = m_cnt[i] + 1; m_wrap[i] = 1'b0;
                end
            end else begin
                m_wrap[i] = 1'b0;
            end
            if (apply && load[i]) begin
                m_amax[i] = max_val; m_pv[i] = 1'b0;
            end else if (apply && m_pv[i]) begin
                m_amax[i] = m_pmax[i]; m_pv[i] = 1'b0;
            end else if (load[i]) begin
                m_pmax[i] = max_val; m_pv[i] = 1'b1;
            end
        end
        m_carry = m_wrap[N-1];
    endfunction

    function automatic logic [W-1:0] cnt_of(input int i);
        return count[i*W +: W];
    endfunction

    function automatic logic [W-1:0] c_cnt_of(input int i);
        return c_count[i*W +: W];
    endfunction

    task automatic tick();
        if (rst_n) model_step();
        @(posedge clk);
        #1;
        evt = '0; clr = '0; load = '0;
        c_evt = '0; c_clr = '0; c_load = '0;
    endtask

    task automatic test_reset();
        int nwrap = 0;
        int wrap_at = 0;
        rst_n = 1'b0;
        evt = '0; en = '0; clr = '0; load = '0; max_val = '0;
        c_evt = '0; c_en = '0; c_clr = '0; c_load = '0; c_max = '0;
        model_reset();
        tick(); tick();
        rst_n = 1'b1;
        tick();
        en = '1; c_en = '1;
        for (int k = 0; k < 5; k++) begin
            evt = '1; c_evt = 3'b001; tick();
        end
        rst_n = 1'b0;
        model_reset();
        #1;
        vectors++;
        if (count !== '0 || c_count !== '0) begin
            miscompares++;
            $display("FAIL async_reset_count: got %0h / %0h expected 0", count, c_count);
        end
        tick(); tick();
        vectors++;
        if (wrap !== '0 || carry !== 1'b0 || c_wrap !== '0 || c_carry !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_strobes: got wrap %b carry %b cwrap %b ccarry %b expected 0",
                     wrap, carry, c_wrap, c_carry);
        end
        rst_n = 1'b1;
        en = 4'b0001; c_en = '0;
        tick();
        for (int k = 1; k <= 115200; k++) begin
            evt[0] = 1'b1;
            tick();
            if (wrap[0]) begin
                nwrap++; wrap_at = k;
            end
            if (k == 115199) begin
                vectors++;
                if (cnt_of(0) !== W'(115199)) begin
                    miscompares++;
                    $display("FAIL default_terminal_count: got %0d expected 115199", cnt_of(0));
                end
            end
        end
        vectors++;
        if (nwrap != 1 || wrap_at != 115200 || cnt_of(0) !== '0) begin
            miscompares++;
            $display("FAIL default_wrap: got %0d wraps, last at %0d, count %0d expected 1 at 115200, count 0",
                     nwrap, wrap_at, cnt_of(0));
        end
    endtask

    task automatic test_small_modulus();
        int exp_seq[12] = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0, 1, 2};
        int nwrap = 0;
        en = 4'b0010;
        load[1] = 1'b1; max_val = W'(4); clr[1] = 1'b1;
        tick();
        for (int k = 0; k < 12; k++) begin
            evt[1] = 1'b1;
            tick();
            if (wrap[1]) nwrap++;
            vectors++;
            if (cnt_of(1) !== W'(exp_seq[k])) begin
                miscompares++;
                $display("FAIL mod5_count[%0d]: got %0d expected %0d", k, cnt_of(1), exp_seq[k]);
            end
        end
        vectors++;
        if (nwrap != 2) begin
            miscompares++;
            $display("FAIL mod5_wraps: got %0d expected 2", nwrap);
        end
        load[1] = 1'b1; max_val = '0; clr[1] = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            evt[1] = 1'b1;
            tick();
            vectors++;
            if (cnt_of(1) !== '0 || wrap[1] !== 1'b1) begin
                miscompares++;
                $display("FAIL mod1_event[%0d]: got count %0d wrap %b expected 0 1", k, cnt_of(1), wrap[1]);
            end
        end
    endtask

    task automatic test_shadow();
        int seq_a[10] = '{4, 5, 6, 7, 8, 9, 0, 1, 2, 0};
        int seq_b[9]  = '{1, 2, 0, 1, 2, 3, 4, 5, 0};
        en = 4'b0100;
        load[2] = 1'b1; max_val = W'(9); clr[2] = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            evt[2] = 1'b1; tick();
        end
        load[2] = 1'b1; max_val = W'(2);
        tick();
        vectors++;
        if (cnt_of(2) !== W'(3)) begin
            miscompares++;
            $display("FAIL shadow_hold: got %0d expected 3", cnt_of(2));
        end
        for (int k = 0; k < 10; k++) begin
            evt[2] = 1'b1;
            tick();
            vectors++;
            if (cnt_of(2) !== W'(seq_a[k]) || wrap[2] !== (seq_a[k] == 0)) begin
                miscompares++;
                $display("FAIL shadow_seq[%0d]: got %0d wrap %b expected %0d", k, cnt_of(2), wrap[2], seq_a[k]);
            end
        end
        for (int k = 0; k < 9; k++) begin
            evt[2] = 1'b1;
            if (k == 2) begin
                load[2] = 1'b1; max_val = W'(5);
            end
            tick();
            vectors++;
            if (cnt_of(2) !== W'(seq_b[k]) || wrap[2] !== (seq_b[k] == 0)) begin
                miscompares++;
                $display("FAIL coincident_load_seq[%0d]: got %0d wrap %b expected %0d", k, cnt_of(2), wrap[2], seq_b[k]);
            end
        end
    endtask

    task automatic test_priority();
        en = 4'b1000;
        load[3] = 1'b1; max_val = W'(3); clr[3] = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            evt[3] = 1'b1; tick();
        end
        clr[3] = 1'b1; evt[3] = 1'b1;
        tick();
        vectors++;
        if (cnt_of(3) !== '0 || wrap[3] !== 1'b0 || carry !== 1'b0) begin
            miscompares++;
            $display("FAIL clr_over_evt: got count %0d wrap %b carry %b expected 0 0 0", cnt_of(3), wrap[3], carry);
        end
        for (int k = 0; k < 2; k++) begin
            evt[3] = 1'b1; tick();
        end
        en = '0;
        for (int k = 0; k < 5; k++) begin
            evt[3] = 1'b1;
            tick();
            vectors++;
            if (cnt_of(3) !== W'(2) || wrap[3] !== 1'b0) begin
                miscompares++;
                $display("FAIL disabled_hold[%0d]: got %0d wrap %b expected 2 0", k, cnt_of(3), wrap[3]);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 3000; k++) begin
            evt = 4'($urandom);
            en  = 4'($urandom) | 4'($urandom);
            for (int i = 0; i < N; i++) begin
                clr[i]  = ($urandom_range(15) == 0);
                load[i] = ($urandom_range(7) == 0);
            end
            max_val = ($urandom_range(15) == 0) ? '1 : W'($urandom_range(6));
            tick();
            for (int i = 0; i < N; i++) begin
                vectors++;
                if (cnt_of(i) !== W'(m_cnt[i]) || wrap[i] !== m_wrap[i]) begin
                    miscompares++;
                    $display("FAIL random_ch%0d cycle %0d: got %0d wrap %b expected %0d wrap %b",
                             i, k, cnt_of(i), wrap[i], m_cnt[i], m_wrap[i]);
                end
            end
            vectors++;
            if (carry !== m_carry) begin
                miscompares++;
                $display("FAIL random_carry cycle %0d: got %b expected %b", k, carry, m_carry);
            end
        end
        en = '0;
    endtask

    task automatic test_cascade();
        int tc = 0;
        int ncarry = 0;
        int budget = 0;
        logic [1:0] noise;
        logic ev0;
        c_en = 3'b111; c_load = 3'b111; c_max = W'(9); c_clr = 3'b111;
        tick();
        while (tc < 1000 && budget < 5000) begin
            budget++;
            ev0 = ($urandom_range(3) != 0);
            noise = 2'($urandom);
            c_evt = {noise, ev0};
            tick();
            if (ev0) tc++;
            if (c_carry) ncarry++;
            vectors++;
            if (c_cnt_of(0) !== W'(tc % 10) || c_cnt_of(1) !== W'((tc / 10) % 10) ||
                c_cnt_of(2) !== W'((tc / 100) % 10)) begin
                miscompares++;
                $display("FAIL cascade_count at %0d events: got %0d,%0d,%0d expected %0d",
                         tc, c_cnt_of(0), c_cnt_of(1), c_cnt_of(2), tc % 1000);
            end
            vectors++;
            if (c_wrap[0] !== (ev0 && tc % 10 == 0) || c_carry !== (ev0 && tc % 1000 == 0)) begin
                miscompares++;
                $display("FAIL cascade_strobe at %0d events: got wrap0 %b carry %b", tc, c_wrap[0], c_carry);
            end
        end
        vectors++;
        if (tc != 1000 || ncarry != 1) begin
            miscompares++;
            $display("FAIL cascade_total: got %0d events %0d carries expected 1000 1", tc, ncarry);
        end
    endtask

    task automatic test_cascade_gating();
        c_clr = 3'b111;
        tick();
        c_en = 3'b101;
        for (int k = 1; k <= 25; k++) begin
            c_evt = 3'($urandom) | 3'b001;
            tick();
            vectors++;
            if (c_cnt_of(0) !== W'(k % 10) || c_cnt_of(1) !== '0 || c_cnt_of(2) !== '0 ||
                c_carry !== 1'b0 || c_wrap[0] !== (k % 10 == 0)) begin
                miscompares++;
                $display("FAIL cascade_gating[%0d]: got %0d,%0d,%0d wrap0 %b carry %b expected %0d,0,0",
                         k, c_cnt_of(0), c_cnt_of(1), c_cnt_of(2), c_wrap[0], c_carry, k % 10);
            end
        end
        c_en = '0;
    endtask

    initial begin
        test_reset();
        test_small_modulus();
        test_shadow();
        test_priority();
        test_random();
        test_cascade();
        test_cascade_gating();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
